toggle_check_arbiter: RTL and testbench
=======================================

# toggle_check_arbiter

Shares one serial toggle-checking datapath between NUM_REQ requesters. Each requester presents a parallel word. The block grants one requester at a time in round-robin order, serializes the granted word LSB-first, counts bit-to-bit toggles, and reports the toggle count and an even/odd flag tagged with the requester ID. It is the scheduler in front of the team's serial toggle-detection state machines.

## Interface
- NUM_REQ, default 4: number of requesters, range 2..16.
- WORD_W, default 8: bits per word, range 2..32.
- ID_W, default $clog2(NUM_REQ): requester ID width.
- CNT_W, default $clog2(WORD_W): toggle-count width; holds at most WORD_W-1.
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- req, in, NUM_REQ: per-requester request level.
- req_data, in, NUM_REQ*WORD_W: requester i's word at bits [i*WORD_W +: WORD_W].
- gnt, out, NUM_REQ: one-hot, one-cycle pulse marking the requester whose word was captured.
- busy, out, 1: high whenever the state is not IDLE.
- ser_out, out, 1: current serialized bit, for an external detector and for observation.
- ser_en, out, 1: high while ser_out carries a valid bit.
- res_valid, out, 1: one-cycle result pulse.
- res_id, out, ID_W: requester ID of the result.
- res_toggles, out, CNT_W: number of toggles in the word.
- res_even, out, 1: 1 when res_toggles is even (0 counts as even).

## Operation
- FSM states: IDLE, SHIFT, REPORT.
- **IDLE:**
  - If req is nonzero, the round-robin arbiter picks the first asserted requester at or after rr_ptr.
  - On that edge: capture the winner's word into shreg, clear bit_cnt, toggle_cnt and first_bit, register the winner's ID, and set gnt to the winner's one-hot.
  - Go to SHIFT.
  - Set rr_ptr to (winner+1) mod NUM_REQ.
- **SHIFT:**
  - ser_out = shreg[0]; ser_en = 1.
  - Each edge: shift shreg right, store the bit in prev_bit, increment bit_cnt.
  - Increment toggle_cnt if this is not the first bit and the bit differs from prev_bit.
  - After the WORD_W-th bit, go to REPORT.
- **REPORT:**
  - res_valid = 1; res_toggles = final count; res_even = ~res_toggles[0]; res_id = latched ID.
  - Next edge: go to IDLE.
- **Requester handshake:**
  - The requester holds req and its data until it sees gnt.
  - req still high in the cycle after gnt counts as a new request.
  - req dropped before it is granted is simply not served; nothing is latched.
- **Request changes while busy:** req changes during SHIFT and REPORT are ignored. Arbitration occurs only in IDLE.
- **Widths:** toggle_cnt saturation is not needed because the maximum is WORD_W-1. bit_cnt is $clog2(WORD_W+1) bits.

## Timing
- **Reset:**
  - Register values: state=IDLE, rr_ptr=0, gnt=0, busy=0, ser_out=0, ser_en=0, res_valid=0, res_id=0, res_toggles=0, res_even=1.
  - Reset during SHIFT or REPORT aborts the word. No res_valid is issued. The requester is not re-served unless it requests again.
- **Grant:** gnt is high in the cycle after the IDLE edge that samples req. That cycle is also the first SHIFT cycle.
- **Serial bits:** ser_en is high for exactly WORD_W consecutive cycles, starting in the gnt cycle.
- **Result:** res_valid is high in cycle gnt+WORD_W, for one cycle.
- **Throughput:** busy covers the WORD_W SHIFT cycles plus the REPORT cycle. IDLE lasts a minimum of one cycle, so the throughput is one word per WORD_W+2 cycles.
- **Arbitration:**
  - Priority after reset is 0 > 1 > … > NUM_REQ-1.
  - If all requests are held continuously, grants rotate 0,1,2,3,0,…
  - A lone requester can be granted back-to-back.

## Structure
- Package toggle_pkg:
  - State enum toggle_sched_state_t {IDLE, SHIFT, REPORT}.
  - Default parameter constants.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, ptr.
  - Outputs: one-hot grant, grant index, any.
  - Combinational. The top level holds the rr_ptr register.

## Test plan
- **Single word, 2 toggles:** reset, then req=4'b0001 with word0=8'h3C → gnt=0001 one cycle, then res_valid 8 cycles later with res_id=0, res_toggles=2, res_even=1.
- **Alternating bits:** word 8'hAA from requester 2 → res_toggles=7, res_even=0. ser_out sequence is 0,1,0,1,0,1,0,1.
- **Zero toggles:** word 8'h00 → res_toggles=0, res_even=1. Word 8'hF0 → res_toggles=1, res_even=0.
- **Round-robin fairness:** req=4'b1111 held → grants 0,1,2,3,0 at 10-cycle spacing. Then req=4'b1010 with rr_ptr=1 → grant order 1,3,1.
- **Request during busy:** req1 rises during requester 0's SHIFT → it is granted only on the first IDLE cycle after REPORT. req3 pulsing only while busy is never granted.
- **Reset mid-operation:** reset asserted at SHIFT bit 4 → the next cycle shows all outputs at reset values and no res_valid. A subsequent request is served normally from rr_ptr=0.

Source files
------------

// File: rtl/toggle_pkg.sv
// Shared types and default sizing for the round-robin toggle-check scheduler.
package toggle_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WORD_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } toggle_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/toggle_check_arbiter.sv
// Round-robin scheduler that serializes one requester word at a time LSB-first
// and reports its bit-to-bit toggle count and parity, tagged with the requester ID.
module toggle_check_arbiter
    import toggle_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WORD_W  = DEF_WORD_W,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = $clog2(WORD_W)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*WORD_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy,
    output logic                      ser_out,
    output logic                      ser_en,
    output logic                      res_valid,
    output logic [ID_W-1:0]           res_id,
    output logic [CNT_W-1:0]          res_toggles,
    output logic                      res_even,
    output toggle_sched_state_t       dbg_state
);

    // Handshake: a requester holds req high and req_data stable until it sees
    // its one-cycle gnt pulse; req is only sampled on IDLE edges, so changes
    // while busy are ignored and a request dropped before its grant is lost.

    localparam int BC_W = $clog2(WORD_W + 1);

    toggle_sched_state_t state, next_state;

    logic [ID_W-1:0]   rr_ptr;
    logic [WORD_W-1:0] shreg;
    logic [BC_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]  toggle_cnt;
    logic              prev_bit;
    logic              first_bit;
    logic [ID_W-1:0]   id_q;
    logic              capture;
    logic              last_bit;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic [WORD_W-1:0]  words [NUM_REQ];

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = req_data[i*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        last_bit   = (bit_cnt == BC_W'(WORD_W - 1));
        case (state)
            IDLE: begin
                if (arb_any) begin
                    next_state = SHIFT;
                    capture    = 1'b1;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    next_state = REPORT;
                end
            end
            REPORT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            gnt        <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            toggle_cnt <= '0;
            prev_bit   <= 1'b0;
            first_bit  <= 1'b1;
            id_q       <= '0;
        end else begin
            gnt <= '0;
            if (capture) begin
                shreg      <= words[arb_idx];
                bit_cnt    <= '0;
                toggle_cnt <= '0;
                first_bit  <= 1'b1;
                id_q       <= arb_idx;
                gnt        <= arb_grant;
                rr_ptr     <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end else if (state == SHIFT) begin
                shreg     <= {1'b0, shreg[WORD_W-1:1]};
                prev_bit  <= shreg[0];
                first_bit <= 1'b0;
                bit_cnt   <= bit_cnt + 1'b1;
                // The first bit has no predecessor, so it can never be a toggle.
                if (!first_bit && (shreg[0] != prev_bit)) begin
                    toggle_cnt <= toggle_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        ser_en      = (state == SHIFT);
        ser_out     = (state == SHIFT) ? shreg[0] : 1'b0;
        res_valid   = (state == REPORT);
        res_id      = id_q;
        res_toggles = toggle_cnt;
        res_even    = ~toggle_cnt[0];
        dbg_state   = state;
    end

endmodule

// File: tb/tb_toggle_check_arbiter.sv
// Scoreboard bench for toggle_check_arbiter: randomized requests against a
// word-level reference model with a decoupled output monitor.
module tb_toggle_check_arbiter;
    import toggle_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int ID_W  = 2;
    localparam int CNT_W = 3;
    localparam int RW    = ID_W + CNT_W + 1;

    logic                clk;
    logic                reset;
    logic [N-1:0]        req;
    logic [N*W-1:0]      req_data;
    logic [N-1:0]        gnt;
    logic                busy;
    logic                ser_out;
    logic                ser_en;
    logic                res_valid;
    logic [ID_W-1:0]     res_id;
    logic [CNT_W-1:0]    res_toggles;
    logic                res_even;
    toggle_sched_state_t dbg_state;

    toggle_check_arbiter #(
        .NUM_REQ (N),
        .WORD_W  (W),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .busy        (busy),
        .ser_out     (ser_out),
        .ser_en      (ser_en),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_toggles (res_toggles),
        .res_even    (res_even),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int m_ptr = 0;
    int mon_since = -1;

    logic [RW-1:0] exp_q[$];
    logic [N-1:0]  gnt_q[$];
    logic          bit_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_toggles(input logic [W-1:0] w);
        int t = 0;
        for (int i = 1; i < W; i++) begin
            if (w[i] != w[i-1]) t++;
        end
        return t;
    endfunction

    task automatic check_reset(input string name);
        check({name, "_outputs"},
              {gnt, busy, ser_out, ser_en, res_valid, res_id, res_toggles, res_even},
              {4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b0, 3'b0, 1'b1});
        check({name, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // driver: one arbitration slot; noise is driven on req while the DUT is busy
    task automatic issue(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic [N-1:0] noise);
        int win;
        int t;
        logic [W-1:0] word;
        @(negedge clk);
        req      = r;
        req_data = d;
        if (r == '0) begin
            @(posedge clk);
            return;
        end
        win = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (win < 0 && r[c]) win = c;
        end
        m_ptr = (win + 1) % N;
        word  = d[win*W +: W];
        t     = ref_toggles(word);
        gnt_q.push_back(N'(1) << win);
        for (int i = 0; i < W; i++) bit_q.push_back(word[i]);
        exp_q.push_back({ID_W'(win), CNT_W'(t), (t % 2 == 0)});
        @(posedge clk);
        @(negedge clk);
        req      = noise;
        req_data = $urandom;
        repeat (W + 1) @(posedge clk);
    endtask

    // driver: start a word, then reset while bit 4 is on ser_out
    task automatic reset_mid(input logic [N-1:0] r, input logic [N*W-1:0] d);
        int win;
        logic [W-1:0] word;
        @(negedge clk);
        req      = r;
        req_data = d;
        win = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (win < 0 && r[c]) win = c;
        end
        word = d[win*W +: W];
        gnt_q.push_back(N'(1) << win);
        for (int i = 0; i < W; i++) bit_q.push_back(word[i]);
        @(posedge clk);
        @(negedge clk);
        req = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        gnt_q.delete();
        bit_q.delete();
        exp_q.delete();
        m_ptr = 0;
        @(posedge clk);
        #1;
        check_reset("mid_reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // monitor / scoreboard
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mon_since = -1;
            end else begin
                if (gnt != '0) begin
                    if (gnt_q.size() > 0) check("gnt", gnt, gnt_q.pop_front());
                    else check("gnt_unexpected", gnt, 0);
                    mon_since = 0;
                end else if (mon_since >= 0) begin
                    mon_since++;
                end
                if (mon_since >= 0 && mon_since <= W) check("busy", busy, 1);
                if (ser_en) begin
                    if (bit_q.size() > 0) check("ser_out", ser_out, bit_q.pop_front());
                    else check("ser_en_unexpected", ser_en, 0);
                end
                if (res_valid) begin
                    if (exp_q.size() > 0) begin
                        check("result", {res_id, res_toggles, res_even}, exp_q.pop_front());
                        check("res_latency", mon_since, W);
                    end else begin
                        check("res_valid_unexpected", res_valid, 0);
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        reset = 1'b0;

        issue(4'b0001, 32'h0000_003C, 4'b0000);
        issue(4'b0100, 32'h00AA_0000, 4'b0000);
        issue(4'b0001, 32'h0000_0000, 4'b0000);
        issue(4'b0001, 32'h0000_00F0, 4'b0000);

        reset_mid(4'b0010, 32'h0000_5500);

        for (int i = 0; i < 5; i++) issue(4'b1111, $urandom, 4'b1111);
        for (int i = 0; i < 3; i++) issue(4'b1010, $urandom, 4'b1010);

        issue(4'b0001, $urandom, 4'b0010);
        issue(4'b0010, $urandom, 4'b1000);
        issue(4'b0001, $urandom, 4'b1000);
        issue(4'b0000, '0, 4'b0000);

        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom_range(1, 15));
            issue(r, $urandom, N'($urandom_range(0, 15)));
        end

        @(negedge clk);
        req = '0;
        repeat (W + 4) @(posedge clk);
        #2;
        check("gnt_q_drained", gnt_q.size(), 0);
        check("bit_q_drained", bit_q.size(), 0);
        check("exp_q_drained", exp_q.size(), 0);
        check("final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
